// File: rtl/execute_pkg.sv
// Shared encodings for the execute stage: ALU ops, branch conditions, RV32M ops, MD FSM states.
// No logic and no state here.
package execute_pkg;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_AUIPC = 4'b1110;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_RUN  = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    function automatic logic md_signed_a(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic md_signed_b(input md_op_e op);
        return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
    endfunction

endpackage

// File: rtl/alu.sv
// Integer ALU for the execute stage.
// Latency: combinational. Backpressure: none.
module ALU
    import execute_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_control,
    output logic [XLEN-1:0] result
);
    localparam int SHW = $clog2(XLEN);

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLT:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_SLL:  result = a << b[SHW-1:0];
            ALU_SRL:  result = a >> b[SHW-1:0];
            ALU_SRA:  result = $unsigned($signed(a) >>> b[SHW-1:0]);
            default:  result = a + b;
        endcase
    end
endmodule

// File: rtl/muldiv_iter.sv
// Iterative RV32M unit: shift-add multiply / restoring divide on magnitudes, one bit per cycle.
// Latency: start -> XLEN RUN cycles -> one DONE cycle with result. Backpressure: busy while RUN.
module muldiv_iter
    import execute_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            flush,
    input  md_op_e          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    md_state_e         state;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    md_op_e            op_q;
    logic              neg_a_q, neg_b_q, div_zero_q;

    logic              neg_a, neg_b, is_div;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN:0]     mul_sum, div_r, div_diff;
    logic [2*XLEN-1:0] next_acc, prod;
    logic [XLEN-1:0]   quo, rem;

    assign neg_a  = md_signed_a(op) & a[XLEN-1];
    assign neg_b  = md_signed_b(op) & b[XLEN-1];
    assign mag_a  = neg_a ? -a : a;
    assign mag_b  = neg_b ? -b : b;
    assign is_div = op[2];

    // Multiply keeps the multiplier in the low half; divide keeps the quotient there.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    assign div_r    = acc[2*XLEN-1:XLEN-1];
    assign div_diff = div_r - {1'b0, opnd};
    assign next_acc = !op_q[2] ? {mul_sum, acc[XLEN-1:1]} :
                      div_diff[XLEN] ? {div_r[XLEN-1:0], acc[XLEN-2:0], 1'b0} :
                                       {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= MD_IDLE;
            cnt        <= '0;
            acc        <= '0;
            opnd       <= '0;
            op_q       <= MD_MUL;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: if (start) begin
                    state      <= MD_RUN;
                    cnt        <= '0;
                    acc        <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    opnd       <= is_div ? mag_b : mag_a;
                    op_q       <= op;
                    neg_a_q    <= neg_a;
                    neg_b_q    <= neg_b;
                    div_zero_q <= (b == '0);
                end
                MD_RUN: if (flush) begin
                    state <= MD_IDLE;
                end else begin
                    acc <= next_acc;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(XLEN-1))
                        state <= MD_DONE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

    assign busy = (state == MD_RUN);
    assign done = (state == MD_DONE);

    assign prod = (neg_a_q ^ neg_b_q) ? -acc : acc;
    assign quo  = acc[XLEN-1:0];
    assign rem  = acc[2*XLEN-1:XLEN];

    // MIN / -1 falls out naturally: the negated magnitude wraps back to MIN.
    always_comb begin
        result = '0;
        case (op_q)
            MD_MUL:                      result = prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: result = prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             result = div_zero_q ? '1 : ((neg_a_q ^ neg_b_q) ? -quo : quo);
            default:                     result = neg_a_q ? -rem : rem;
        endcase
    end
endmodule

// File: rtl/execute_stage_md.sv
// RV32IM execute stage: forwarding, ALU, branch resolution, iterative mul/div, EX/MEM register.
// Latency: 1 cycle for non-M ops, XLEN+2 for M ops. Backpressure: StallE holds the front end during M ops.
module execute_stage_md
    import execute_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            ALUSrcE,
    input  logic            MemWriteE,
    input  logic            ResultSrcE,
    input  logic            BranchE,
    input  logic            JumpE,
    input  logic            JalrE,
    input  logic            MdE,
    input  logic [3:0]      ALUControlE,
    input  logic [2:0]      funct3E,
    input  logic [XLEN-1:0] RD1_E,
    input  logic [XLEN-1:0] RD2_E,
    input  logic [XLEN-1:0] Imm_Ext_E,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic [4:0]      RD_E,
    input  logic [1:0]      ForwardA_E,
    input  logic [1:0]      ForwardB_E,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] ResultW,
    input  logic            FlushE,
    output logic            StallE,
    output logic            PCSrcE,
    output logic [XLEN-1:0] PCTargetE,
    output logic            RegWriteM,
    output logic            MemWriteM,
    output logic            ResultSrcM,
    output logic [4:0]      RD_M,
    output logic [2:0]      funct3M,
    output logic [XLEN-1:0] PCPlus4M,
    output logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ALU_ResultM_out
);
    typedef struct packed {
        logic            reg_write;
        logic            mem_write;
        logic            result_src;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [XLEN-1:0] pc_plus4;
        logic [XLEN-1:0] write_data;
        logic [XLEN-1:0] alu_result;
    } exmem_t;

    logic [XLEN-1:0] src_a, fwd_b, src_b, alu_result, pc_imm, jalr_sum, ex_result, md_result;
    logic            taken, md_start, md_busy, md_done, md_idle;
    logic [4:0]      md_rd;
    exmem_t          exmem_d, exmem_q;

    always_comb begin
        case (ForwardA_E)
            2'b10:   src_a = ALU_ResultM;
            2'b01:   src_a = ResultW;
            default: src_a = RD1_E;
        endcase
        case (ForwardB_E)
            2'b10:   fwd_b = ALU_ResultM;
            2'b01:   fwd_b = ResultW;
            default: fwd_b = RD2_E;
        endcase
    end
    assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

    ALU #(.XLEN(XLEN)) u_alu (
        .a           (src_a),
        .b           (src_b),
        .alu_control (ALUControlE),
        .result      (alu_result)
    );

    always_comb begin
        case (funct3E)
            BR_BEQ:  taken = (src_a == src_b);
            BR_BNE:  taken = (src_a != src_b);
            BR_BLT:  taken = ($signed(src_a) <  $signed(src_b));
            BR_BGE:  taken = ($signed(src_a) >= $signed(src_b));
            BR_BLTU: taken = (src_a <  src_b);
            BR_BGEU: taken = (src_a >= src_b);
            default: taken = 1'b0;
        endcase
    end

    assign pc_imm    = PCE + Imm_Ext_E;
    assign jalr_sum  = src_a + Imm_Ext_E;
    assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : pc_imm;
    assign PCSrcE    = ~FlushE & ~MdE & ((BranchE & taken) | JumpE | JalrE);
    assign ex_result = (JumpE | JalrE) ? PCPlus4E :
                       (ALUControlE == ALU_AUIPC) ? pc_imm : alu_result;

    assign md_start = MdE & ~FlushE;

    muldiv_iter #(.XLEN(XLEN), .CNT_W(CNT_W)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .flush  (FlushE),
        .op     (md_op_e'(funct3E)),
        .a      (src_a),
        .b      (src_b),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    assign md_idle = ~md_busy & ~md_done;
    assign StallE  = (md_idle & md_start) | md_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            md_rd <= '0;
        else if (md_idle & md_start)
            md_rd <= RD_E;
    end

    always_comb begin
        exmem_d = '{reg_write: RegWriteE, mem_write: MemWriteE, result_src: ResultSrcE,
                    rd: RD_E, funct3: funct3E, pc_plus4: PCPlus4E,
                    write_data: fwd_b, alu_result: ex_result};
        if (FlushE | StallE | (md_idle & MdE)) begin
            exmem_d.reg_write  = 1'b0;
            exmem_d.mem_write  = 1'b0;
            exmem_d.result_src = 1'b0;
            exmem_d.rd         = 5'd0;
        end else if (md_done) begin
            exmem_d.reg_write  = 1'b1;
            exmem_d.mem_write  = 1'b0;
            exmem_d.result_src = 1'b0;
            exmem_d.rd         = md_rd;
            exmem_d.alu_result = md_result;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            exmem_q <= '0;
        else
            exmem_q <= exmem_d;
    end

    assign RegWriteM       = exmem_q.reg_write;
    assign MemWriteM       = exmem_q.mem_write;
    assign ResultSrcM      = exmem_q.result_src;
    assign RD_M            = exmem_q.rd;
    assign funct3M         = exmem_q.funct3;
    assign PCPlus4M        = exmem_q.pc_plus4;
    assign WriteDataM      = exmem_q.write_data;
    assign ALU_ResultM_out = exmem_q.alu_result;
endmodule

// File: tb/tb_execute_stage_md.sv
// Scoreboard bench for execute_stage_md: directed vectors push expected writebacks, a monitor pops them.
module tb_execute_stage_md;
    logic        clk, rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, JalrE, MdE;
    logic [3:0]  ALUControlE;
    logic [2:0]  funct3E;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic [31:0] ALU_ResultM, ResultW;
    logic        FlushE;
    logic        StallE, PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [2:0]  funct3M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM_out;

    execute_stage_md dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE), .MdE(MdE),
        .ALUControlE(ALUControlE), .funct3E(funct3E),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .RD_E(RD_E), .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .ALU_ResultM(ALU_ResultM), .ResultW(ResultW), .FlushE(FlushE),
        .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .funct3M(funct3M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM_out(ALU_ResultM_out)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_ins();
        RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0; ResultSrcE = 0;
        BranchE = 0; JumpE = 0; JalrE = 0; MdE = 0; FlushE = 0;
        ALUControlE = 4'b0000; funct3E = 3'b000;
        RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0; PCPlus4E = 0; RD_E = 0;
        ForwardA_E = 2'b00; ForwardB_E = 2'b00; ALU_ResultM = 0; ResultW = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wb(input logic [4:0] rd, input logic [31:0] val);
        exp_t e;
        e.rd  = rd;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // mode 0: operands from RF; 1: SrcA forwarded from MEM then disturbed mid-run; 2: SrcB from WB
    task automatic run_md(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                          input int mode);
        int cnt;
        clear_ins();
        MdE = 1; RegWriteE = 1; funct3E = f3; RD1_E = a; RD2_E = b; RD_E = rd;
        if (mode == 1) begin
            ForwardA_E = 2'b10; ALU_ResultM = a; RD1_E = 32'h0BAD_0BAD;
        end else if (mode == 2) begin
            ForwardB_E = 2'b01; ResultW = b; RD2_E = 32'h0;
        end
        expect_wb(rd, exp);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!StallE) break;
            cnt++;
            if (mode == 1 && cnt == 5) begin
                ALU_ResultM = 32'd100; ForwardA_E = 2'b01; ResultW = 32'd55;
            end
        end
        check({name, "_stall_cycles"}, cnt, 33);
        tick();
        clear_ins();
    endtask

    always @(negedge clk) begin
        if (!rst && RegWriteM) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected: got rd=%0d val=0x%0h expected no writeback", RD_M, ALU_ResultM_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (RD_M !== e.rd || ALU_ResultM_out !== e.val) begin
                    failures++;
                    $display("FAIL wb_result: got rd=%0d val=0x%0h expected rd=%0d val=0x%0h",
                             RD_M, ALU_ResultM_out, e.rd, e.val);
                end
            end
        end
    end

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic        tk;
    } br_t;

    br_t br_tab[7] = '{
        '{3'b110, 32'hFFFF_FFFF, 32'h1, 1'b0},   // BLTU
        '{3'b100, 32'hFFFF_FFFF, 32'h1, 1'b1},   // BLT
        '{3'b000, 32'h5,         32'h5, 1'b1},   // BEQ
        '{3'b001, 32'h5,         32'h5, 1'b0},   // BNE
        '{3'b101, 32'hFFFF_FFFF, 32'h1, 1'b0},   // BGE
        '{3'b111, 32'hFFFF_FFFF, 32'h1, 1'b1},   // BGEU
        '{3'b010, 32'h5,         32'h5, 1'b0}    // undefined code
    };

    initial begin
        int cnt;
        rst = 1'b1;
        clear_ins();
        @(negedge clk);
        @(negedge clk);
        check("rst_stall", StallE, 0);
        check("rst_ctrl", {RegWriteM, MemWriteM, ResultSrcM, RD_M, funct3M}, 0);
        check("rst_data", PCPlus4M | WriteDataM | ALU_ResultM_out, 0);
        rst = 1'b0;
        tick();

        // ADDI x5,x0,7
        clear_ins();
        RegWriteE = 1; ALUSrcE = 1; Imm_Ext_E = 32'd7; RD_E = 5'd5;
        expect_wb(5'd5, 32'd7);
        tick();

        // SUB with A forwarded from WB and B from MEM: 20 - 5
        clear_ins();
        RegWriteE = 1; ALUControlE = 4'b0001; RD_E = 5'd6; RD1_E = 32'd999; RD2_E = 32'd999;
        ForwardA_E = 2'b01; ResultW = 32'd20; ForwardB_E = 2'b10; ALU_ResultM = 32'd5;
        expect_wb(5'd6, 32'd15);
        tick();

        foreach (br_tab[i]) begin
            clear_ins();
            BranchE = 1; funct3E = br_tab[i].f3; RD1_E = br_tab[i].a; RD2_E = br_tab[i].b;
            PCE = 32'h100; Imm_Ext_E = 32'h40;
            #1;
            check($sformatf("branch_taken_f3_%0d", br_tab[i].f3), PCSrcE, br_tab[i].tk);
            if (br_tab[i].tk) check("branch_target", PCTargetE, 32'h140);
            tick();
        end

        // Flushed JAL: no redirect, no writeback
        clear_ins();
        JumpE = 1; FlushE = 1; RegWriteE = 1; RD_E = 5'd3;
        #1;
        check("flushed_jump_pcsrc", PCSrcE, 0);
        tick();

        // Flushed M op must not start the unit
        clear_ins();
        MdE = 1; FlushE = 1; RegWriteE = 1; RD_E = 5'd4;
        #1;
        check("flushed_md_stall", StallE, 0);
        tick();
        clear_ins();
        @(negedge clk);
        check("flushed_md_no_run", StallE, 0);
        tick();

        run_md("mul",      3'b000, 32'hFFFF_FFFD, 32'd5,         5'd7,  32'hFFFF_FFF1, 0);
        run_md("mulh",     3'b001, 32'hFFFF_FFFD, 32'd5,         5'd8,  32'hFFFF_FFFF, 0);
        run_md("mulhsu",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 0);
        run_md("mulhu",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFE, 0);
        run_md("div_ovf",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 0);
        run_md("rem_ovf",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0,         0);
        run_md("divu_z",   3'b101, 32'd9,         32'd0,         5'd13, 32'hFFFF_FFFF, 0);
        run_md("remu_z",   3'b111, 32'd9,         32'd0,         5'd14, 32'd9,         0);
        run_md("div_neg",  3'b100, 32'hFFFF_FFF9, 32'd2,         5'd15, 32'hFFFF_FFFD, 0);
        run_md("rem_neg",  3'b110, 32'hFFFF_FFF9, 32'd2,         5'd16, 32'hFFFF_FFFF, 0);
        run_md("div_z",    3'b100, 32'hFFFF_FFF9, 32'd0,         5'd17, 32'hFFFF_FFFF, 0);
        run_md("rem_z",    3'b110, 32'hFFFF_FFF9, 32'd0,         5'd18, 32'hFFFF_FFF9, 0);
        run_md("divu_fwd", 3'b101, 32'd12,        32'd4,         5'd19, 32'd3,         1);

        // Reset in RUN cycle 10: operation discarded, outputs cleared at once
        clear_ins();
        MdE = 1; RegWriteE = 1; RD1_E = 32'd3; RD2_E = 32'd3; RD_E = 5'd9;
        cnt = 0;
        for (int i = 0; i < 100 && cnt < 11; i++) begin
            @(negedge clk);
            if (StallE) cnt++;
        end
        rst = 1'b1;
        clear_ins();
        #1;
        check("midrun_rst_stall", StallE, 0);
        check("midrun_rst_ctrl", {RegWriteM, MemWriteM, ResultSrcM, RD_M, funct3M}, 0);
        check("midrun_rst_data", PCPlus4M | WriteDataM | ALU_ResultM_out, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_md("mul_after_rst", 3'b000, 32'd6, 32'd7, 5'd10, 32'd42, 2);

        // JALR x1, 4(x?) with SrcA = 0x1003
        clear_ins();
        JalrE = 1; RegWriteE = 1; ALUSrcE = 1; RD1_E = 32'h1003; Imm_Ext_E = 32'd4;
        PCE = 32'h2000; PCPlus4E = 32'h2004; RD_E = 5'd1;
        #1;
        check("jalr_target", PCTargetE, 32'h1006);
        check("jalr_pcsrc", PCSrcE, 1);
        expect_wb(5'd1, 32'h2004);
        tick();

        // AUIPC
        clear_ins();
        ALUControlE = 4'b1110; ALUSrcE = 1; RegWriteE = 1; PCE = 32'h3000; Imm_Ext_E = 32'h5000;
        RD_E = 5'd2;
        expect_wb(5'd2, 32'h8000);
        tick();

        clear_ins();
        repeat (3) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute stage for the 5-stage RV32IM pipeline: forwarding muxes, ALU, full branch/jump resolution (all six RV32I branch conditions), and a new iterative multiply/divide unit (RV32M) that stalls the front end while it runs. It sits between the ID/EX and EX/MEM registers. It owns the EX/MEM register, which receives bubbles while a multi-cycle operation is in flight.

## Interface
Parameters:
- `XLEN`, 32: datapath width. Must be a power of two, at least 8.
- `CNT_W`, $clog2(XLEN): width of the iteration counter.

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE, JumpE, JalrE, MdE`  in  1 each  decoded controls. `MdE` marks an RV32M instruction.
- `ALUControlE`  in  4  ALU operation. 4'b1110 means AUIPC.
- `funct3E`  in  3  branch condition, load/store size, or M-op select.
- `RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E`  in  XLEN each  operands.
- `RD_E`  in  5  destination register.
- `ForwardA_E, ForwardB_E`  in  2 each  forward select: 10 = MEM, 01 = WB, 00 = register file.
- `ALU_ResultM, ResultW`  in  XLEN each  forwarding sources.
- `FlushE`  in  1  kills the instruction in EX.
- `StallE`  out  1  hold PC, IF/ID and ID/EX.
- `PCSrcE`  out  1  redirect.
- `PCTargetE`  out  XLEN  redirect target.
- `RegWriteM, MemWriteM, ResultSrcM`  out  1 each  registered controls.
- `RD_M`  out  5  registered destination register.
- `funct3M`  out  3  registered funct3.
- `PCPlus4M, WriteDataM, ALU_ResultM_out`  out  XLEN each  registered data.

## Operation
- **SrcA/SrcB:** forwarding as encoded above. `SrcB` = `Imm_Ext_E` when `ALUSrcE`, else the forwarded RD2.
- **Branch conditions on `funct3E`:**
  - 000 BEQ, 001 BNE, 100 BLT signed, 101 BGE signed, 110 BLTU, 111 BGEU.
  - Comparisons are computed directly on SrcA/SrcB, not from ALU flags.
  - Other codes: not taken.
- **Redirect:** `PCSrcE = ~FlushE & ~MdE & ((BranchE & taken) | JumpE | JalrE)`.
- **Redirect target:** `PCTargetE` = JALR ? `(SrcA+Imm) & ~1` : `PCE+Imm`.
- **Result mux** (non-M path, into EX/MEM): `JumpE|JalrE` → `PCPlus4E`; AUIPC → `PCE+Imm`; else ALU result.
- **M-op select (`funct3E`):** 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- **MD FSM states:** IDLE, RUN, DONE.
  - IDLE → RUN when `MdE & ~FlushE`. Capture |SrcA|, |SrcB|, sign flags and op. Clear the counter.
  - RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per cycle. Accumulator is 2·XLEN wide. Counter increments.
  - RUN → DONE when the counter reaches XLEN-1.
  - DONE: apply sign correction and select the low or high half. Then go to IDLE.
- **Edge cases:**
  - Divide by zero: quotient = all ones, remainder = dividend. No trap.
  - Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- **StallE:** `(state==IDLE & MdE & ~FlushE) | state==RUN`. It is low in DONE, so ID/EX advances on the DONE edge.
- **EX/MEM register:**
  - Loads a bubble (RegWriteM = MemWriteM = ResultSrcM = 0, RD_M = 0) whenever `FlushE`, or `StallE`, or the FSM is in IDLE with `MdE`.
  - In DONE, loads the M result with RegWriteM = 1 and the captured RD.
  - Otherwise loads the normal E values.
- **Flush during RUN or DONE:** `FlushE` returns the FSM to IDLE and loads a bubble. Hazard logic never does this, but the required behaviour is defined.
- **Operand capture:** operands are captured at issue. Forward-select changes during RUN have no effect.

## Timing
- Non-M instructions: one cycle. EX/MEM updates at the next edge.
- M instructions, issued in cycle t:
  - `StallE` is high in cycles t … t+XLEN.
  - DONE is cycle t+XLEN+1.
  - The result is visible on `ALU_ResultM_out` after the edge ending t+XLEN+1.
  - Latency: XLEN+2 cycles. Back-to-back M ops are separated by exactly one DONE cycle.
- Reset (async): FSM = IDLE, counter = 0, accumulator = 0, every registered output = 0. Asserting reset mid-RUN discards the operation. `StallE` drops combinationally.

## Structure
- Shared package `execute_pkg`:
  - ALUControl encodings (including AUIPC 4'b1110).
  - `md_op_e` (the eight M-op codes).
  - Branch funct3 constants.
  - `md_state_e` {IDLE, RUN, DONE}.
- Sub-modules:
  - `muldiv_iter` (parametrised on XLEN): FSM, counter, accumulator, sign fix-up. Handshake is start/busy/done/result.
  - The existing `ALU` is reused unchanged, widened via XLEN.

## Test plan
- ADDI x5,x0,7 followed by BLTU with SrcA = 0xFFFF_FFFF, SrcB = 1 → not taken. Same operands with BLT → taken, and `PCTargetE` = PCE+Imm.
- MUL with SrcA = -3, SrcB = 5:
  - `StallE` high for 33 cycles.
  - `ALU_ResultM_out` = 0xFFFF_FFF1, RegWriteM = 1.
  - MULH with the same operands → 0xFFFF_FFFF.
- DIV 0x8000_0000 / -1 → 0x8000_0000. REM of the same → 0. DIVU 9 / 0 → 0xFFFF_FFFF. REMU 9 / 0 → 9.
- ForwardA = 10 (MEM value 12) at issue, then ALU_ResultM changed during RUN → DIVU 12/4 = 3, unaffected by the change.
- Reset asserted at RUN cycle 10 → all outputs 0 and `StallE` = 0 immediately. The next MUL 6×7 → 42.
- JALR with SrcA = 0x1003, Imm = 4 → `PCTargetE` = 0x1006, `ALU_ResultM_out` = PCPlus4E.
